ez8_uart_loader: RTL

- Serial boot loader that drives the instruction-memory write port of ez8_cpu: instr_writeaddr, instr_writedata and instr_write_en.
- Receives a framed program image over a UART RX line (8N1) and writes it word by word into instruction memory.
- Holds the CPU in reset/pause for the whole load and releases it only after the checksum verifies.
- Sits in the board top level next to the CPU; the top ORs cpu_hold with the board reset.

---
 rtl/ez8_uart_loader.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ez8_uart_loader.sv
// Serial boot loader: receives a framed program image over 8N1 UART and writes it
// into ez8_cpu instruction memory, holding the CPU until the checksum verifies.
module ez8_uart_loader #(
    parameter int unsigned CLKS_PER_BIT   = 434,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        uart_rx,
    output logic [11:0] instr_writeaddr,
    output logic [15:0] instr_writedata,
    output logic        instr_write_en,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error
);
    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [2:0] P_IDLE   = 3'd0;
    localparam logic [2:0] P_LEN_HI = 3'd1;
    localparam logic [2:0] P_LEN_LO = 3'd2;
    localparam logic [2:0] P_D_HI   = 3'd3;
    localparam logic [2:0] P_D_LO   = 3'd4;
    localparam logic [2:0] P_CHECK  = 3'd5;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [15:0] MAX_WORDS = 16'd4096;

    logic          rx_meta;
    logic          rx_sync;
    logic [1:0]    rx_state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    rx_data;
    logic          byte_valid;
    logic          frame_err;

    logic [2:0]    pstate;
    logic [7:0]    len_hi;
    logic [7:0]    hi_byte;
    logic [7:0]    checksum;
    logic [12:0]   word_count;
    logic [12:0]   idx;
    logic [TW-1:0] tcnt;
    logic          timeout_hit;

    // UART receiver
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_state   <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_data    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= uart_rx;
            rx_sync    <= rx_meta;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_sync) begin
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                        clk_cnt  <= '0;
                        bit_idx  <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt  <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_data    <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // tcnt holds the number of cycles since the last byte_valid, so the error
    // register rises exactly TIMEOUT_CYCLES cycles after that strobe.
    always_comb begin
        timeout_hit = (pstate != P_IDLE) && !byte_valid &&
                      (tcnt == TW'(TIMEOUT_CYCLES - 1));
    end

    // Frame protocol
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pstate          <= P_IDLE;
            len_hi          <= '0;
            hi_byte         <= '0;
            checksum        <= '0;
            word_count      <= '0;
            idx             <= '0;
            tcnt            <= TW'(1);
            instr_writeaddr <= '0;
            instr_writedata <= '0;
            instr_write_en  <= 1'b0;
            cpu_hold        <= 1'b0;
            load_done       <= 1'b0;
            load_error      <= 1'b0;
        end else begin
            instr_write_en <= 1'b0;
            load_done      <= 1'b0;

            if (pstate == P_IDLE || byte_valid) begin
                tcnt <= TW'(1);
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            if (pstate != P_IDLE && (frame_err || timeout_hit)) begin
                load_error <= 1'b1;
                pstate     <= P_IDLE;
            end else if (byte_valid) begin
                case (pstate)
                    P_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            cpu_hold   <= 1'b1;
                            load_error <= 1'b0;
                            checksum   <= '0;
                            idx        <= '0;
                            pstate     <= P_LEN_HI;
                        end
                    end
                    P_LEN_HI: begin
                        len_hi <= rx_data;
                        pstate <= P_LEN_LO;
                    end
                    P_LEN_LO: begin
                        if ({len_hi, rx_data} > MAX_WORDS) begin
                            load_error <= 1'b1;
                            pstate     <= P_IDLE;
                        end else if ({len_hi, rx_data} == 16'd0) begin
                            pstate <= P_CHECK;
                        end else begin
                            word_count <= {len_hi[4:0], rx_data};
                            pstate     <= P_D_HI;
                        end
                    end
                    P_D_HI: begin
                        hi_byte  <= rx_data;
                        checksum <= checksum ^ rx_data;
                        pstate   <= P_D_LO;
                    end
                    P_D_LO: begin
                        instr_write_en  <= 1'b1;
                        instr_writeaddr <= idx[11:0];
                        instr_writedata <= {hi_byte, rx_data};
                        checksum        <= checksum ^ rx_data;
                        idx             <= idx + 1'b1;
                        if (idx + 13'd1 == word_count) begin
                            pstate <= P_CHECK;
                        end else begin
                            pstate <= P_D_HI;
                        end
                    end
                    P_CHECK: begin
                        if (rx_data == checksum) begin
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else begin
                            load_error <= 1'b1;
                        end
                        pstate <= P_IDLE;
                    end
                    default: pstate <= P_IDLE;
                endcase
            end
        end
    end
endmodule
